// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states,
// counter width, divide-by-zero result and small operand helpers.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Per-operation context captured at launch and consumed at the fix-up step.
    typedef struct packed {
        logic is_div;
        logic neg_res;
        logic neg_rem;
    } ctx_t;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider on the {hi,lo} accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] acc_hi_c,
    output logic [XLEN-1:0] acc_lo_c
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic          fits;

    always_comb begin
        sum      = '0;
        shifted  = '0;
        fits     = 1'b0;
        acc_hi_c = acc_hi;
        acc_lo_c = acc_lo;
        if (is_div) begin
            // Remainder shifted left by one pulls in the next dividend bit from lo.
            shifted  = {acc_hi, acc_lo[XLEN-1]};
            fits     = (shifted >= {1'b0, opnd});
            acc_hi_c = fits ? (shifted[XLEN-1:0] - opnd) : shifted[XLEN-1:0];
            acc_lo_c = {acc_lo[XLEN-2:0], fits};
        end else begin
            // Multiplier sits in lo; its LSB gates the add, carry shifts into hi.
            sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (XLEN+1)'(0));
            acc_hi_c = sum[XLEN:1];
            acc_lo_c = {sum[0], acc_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multicycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operates on magnitudes for 32 iterations, then applies sign correction in a final fix-up cycle.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic            flush,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    ctx_t              ctx_q, ctx_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    op_e               op_w;
    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   step_hi_c, step_lo_c;
    logic [2*XLEN-1:0] prod;

    assign op_w  = op_e'(op);
    assign sgn_a = op_is_signed(op_w) & a[XLEN-1];
    assign sgn_b = op_is_signed(op_w) & b[XLEN-1];
    assign mag_a = cond_neg(a, sgn_a);
    assign mag_b = cond_neg(b, sgn_b);

    muldiv_step u_step (
        .is_div   (ctx_q.is_div),
        .acc_hi   (acc_hi_q),
        .acc_lo   (acc_lo_q),
        .opnd     (opnd_q),
        .acc_hi_c (step_hi_c),
        .acc_lo_c (step_lo_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        ctx_d    = ctx_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        prod     = {acc_hi_q, acc_lo_q};

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    ctx_d.is_div  = op_is_div(op_w);
                    ctx_d.neg_res = sgn_a ^ sgn_b;
                    ctx_d.neg_rem = sgn_a;
                    acc_hi_d      = '0;
                    // Divide: dividend in lo, divisor held. Multiply: multiplier in lo.
                    acc_lo_d      = op_is_div(op_w) ? mag_a : mag_b;
                    opnd_d        = op_is_div(op_w) ? mag_b : mag_a;
                    cnt_d         = '1;
                    state_d       = ST_RUN;
                end else if (!start) begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            ST_RUN: begin
                acc_hi_d = step_hi_c;
                acc_lo_d = step_lo_c;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (ctx_q.is_div) begin
                    // Divide by zero leaves |a| as remainder, so restoring the sign yields a.
                    hi_d = cond_neg(acc_hi_q, ctx_q.neg_rem);
                    lo_d = (opnd_q == '0) ? DIV0_LO : cond_neg(acc_lo_q, ctx_q.neg_res);
                end else begin
                    prod = ctx_q.neg_res ? (2*XLEN)'(-prod) : prod;
                    hi_d = prod[2*XLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Squash beats completion: no HI/LO write and no done pulse.
        if (flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            ctx_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            ctx_q    <= ctx_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random ops against an
// arithmetic reference model of HI/LO.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .flush (flush),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero, remainder follows dividend.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        logic [63:0]     p;
        p = '0;
        case (o)
            2'b00: p = 64'(sx * sy);
            2'b01: p = 64'(ux * uy);
            2'b10: begin
                if (y == 32'd0)                                  p = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else                                             p = {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else            p = {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    // Launch one op; optionally poke mtlo with the start and start/mthi mid-run (all must be ignored).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
        int cyc;
        logic [31:0] eh, el;
        model(o, x, y, eh, el);
        start = 1'b1; op = o; a = x; b = y; mtlo = poke;
        step();
        start = 1'b0; mtlo = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("lo_hold_at_start", lo, cur_lo);
        cyc = 0;
        while (busy && cyc < 40) begin
            if (poke && cyc == 7) begin
                start = 1'b1; op = ~o; a = ~x; b = y + 32'd1; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0; mthi = 1'b0;
        chk("busy_cycles", 32'(cyc), 32'd33);
        chk("done_pulse", 32'(done), 32'd1);
        chk("hi_result", hi, eh);
        chk("lo_result", lo, el);
        cur_hi = eh;
        cur_lo = el;
        step();
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

        // mthi+mtlo together, then mthi alone
        a = 32'h5555_0000; mthi = 1'b1; mtlo = 1'b1;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", hi, 32'h5555_0000);
        chk("mt_both_lo", lo, 32'h5555_0000);
        a = 32'h1111; mthi = 1'b1;
        step();
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h1111);
        chk("mthi_lo", lo, 32'h5555_0000);
        cur_hi = 32'h1111; cur_lo = 32'h5555_0000;

        // flush beats start while idle
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_beats_start", 32'(busy), 32'd0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b11, 32'h1234, 32'd0, 1'b1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0);

        // Flush mid-RUN with a stray start while busy
        a = 32'hAA; mtlo = 1'b1;
        step();
        mtlo = 1'b0;
        chk("mtlo_aa", lo, 32'hAA);
        cur_lo = 32'hAA;
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; a = 32'd9;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("busy_before_flush", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_lo", lo, 32'hAA);
        chk("flush_hi", hi, cur_hi);
        step();
        chk("flush_no_done_later", 32'(done), 32'd0);
        chk("flush_no_restart", 32'(busy), 32'd0);

        // Async reset mid-RUN
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        cur_hi = '0; cur_lo = '0;
        #1 rst = 1'b0;
        step();
        run_op(2'b01, 32'd6, 32'd7, 1'b0);

        // Random ops with occasional corner operands
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) begin ra = 32'($urandom_range(0, 200)) - 32'd100; rb = 32'($urandom_range(1, 20)); end
            run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
